lane_cfg_sequencer: RTL and testbench

- Controller that configures the per-lane data inputs of a generate-replicated lane array, with one 1-bit `sub` instance per lane.
- Accepts a new per-lane bit pattern serially over a valid/ready stream and stages it in a shadow register.
- Commits the pattern atomically to the lanes, then reads back the lane outputs and flags any mismatch.
- Sits between a configuration source and the lane array; `lane_data_o[i]` drives lane i's `data_i`, and lane i's `o` returns on `lane_o_i[i]`.

---
 rtl/lane_cfg_pkg.sv | 18 +
 rtl/lane_cfg_shadow.sv | 28 ++
 rtl/lane_cfg_sequencer.sv | 115 +++++++++++
 tb/tb_lane_cfg_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lane_cfg_pkg.sv
// Shared types and helpers for the lane configuration sequencer.
//   lane_cfg_state_e : controller state encoding
//   lane_idx_w()     : width of the serial lane index, max(1, clog2(lanes))
package lane_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    COMMIT = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } lane_cfg_state_e;

  function automatic int lane_idx_w(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/lane_cfg_shadow.sv
// Shadow register that collects a per-lane pattern one bit at a time.
//   clk, rst : clock and synchronous active-high reset (clears the pattern)
//   clr      : synchronous clear at the start of a new load
//   wr_en    : write wr_bit into position wr_idx
//   shadow   : staged pattern, bit i belongs to lane i
module lane_cfg_shadow
  import lane_cfg_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [lane_idx_w(LANES)-1:0] wr_idx,
  input  logic                         wr_bit,
  output logic [LANES-1:0]             shadow
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shadow <= '0;
    end else if (wr_en) begin
      shadow[wr_idx] <= wr_bit;
    end
  end

endmodule

// File: rtl/lane_cfg_sequencer.sv
// Loads a per-lane bit pattern serially, commits it atomically to a lane
// array, then compares the lanes' returned outputs against what was driven.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : begin a new load (accepted only when idle)
//   bit_valid_i  : serial bit valid; bit_ready_o is high only while loading
//   bit_i        : serial bit, first accepted bit goes to lane 0
//   lane_data_o  : committed per-lane data driven to the lane array
//   lane_o_i     : lane outputs returned for readback
//   busy_o       : high whenever not idle
//   done_o       : one-cycle completion pulse
//   err_o        : sticky readback mismatch, cleared on an accepted start
module lane_cfg_sequencer
  import lane_cfg_pkg::*;
#(
  parameter int               LANES         = 4,
  parameter logic [LANES-1:0] RESET_PATTERN = LANES'('hA),
  parameter int               CHECK_WAIT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  output logic             bit_ready_o,
  output logic [LANES-1:0] lane_data_o,
  input  logic [LANES-1:0] lane_o_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int               IDX_W     = lane_idx_w(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LANES - 1);
  localparam logic [3:0]       WAIT_LAST = 4'(CHECK_WAIT - 1);

  lane_cfg_state_e  state_q, state_d;
  logic [IDX_W-1:0] lane_idx_q;
  logic [3:0]       wait_cnt_q;
  logic [LANES-1:0] shadow;
  logic             start_acc;
  logic             handshake;
  logic             check_last;

  assign start_acc  = (state_q == IDLE) && start_i;
  assign handshake  = (state_q == LOAD) && bit_valid_i;
  assign check_last = (state_q == CHECK) && (wait_cnt_q == WAIT_LAST);

  assign bit_ready_o = (state_q == LOAD);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

  lane_cfg_shadow #(
    .LANES (LANES)
  ) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_acc),
    .wr_en  (handshake),
    .wr_idx (lane_idx_q),
    .wr_bit (bit_i),
    .shadow (shadow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    if (bit_valid_i && (lane_idx_q == LAST_IDX)) state_d = COMMIT;
      COMMIT:  state_d = CHECK;
      CHECK:   if (wait_cnt_q == WAIT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane data is only ever replaced whole at COMMIT, so the lane array
  // never sees a partially loaded pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx_q  <= '0;
      wait_cnt_q  <= '0;
      err_o       <= 1'b0;
      lane_data_o <= RESET_PATTERN;
    end else begin
      if (start_acc) begin
        lane_idx_q <= '0;
        err_o      <= 1'b0;
      end
      // Index saturates at the last lane; the transition out of LOAD
      // happens on that same handshake.
      if (handshake && (lane_idx_q != LAST_IDX)) begin
        lane_idx_q <= lane_idx_q + IDX_W'(1);
      end
      if (state_q == COMMIT) begin
        lane_data_o <= shadow;
        wait_cnt_q  <= '0;
      end
      if (state_q == CHECK) begin
        wait_cnt_q <= wait_cnt_q + 4'd1;
      end
      if (check_last && (lane_o_i != lane_data_o)) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lane_cfg_sequencer.sv
module tb_lane_cfg_sequencer;

  localparam int LANES = 4;
  localparam int CW    = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             bit_valid_i = 1'b0;
  logic             bit_i = 1'b0;
  logic             bit_ready_o;
  logic [LANES-1:0] lane_data_o;
  logic [LANES-1:0] lane_o_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  logic             tie_en = 1'b0;
  logic [LANES-1:0] tie_val = '0;
  logic [LANES-1:0] last_pat;

  int tests = 0;
  int fails = 0;

  assign lane_o_i = tie_en ? tie_val : lane_data_o;

  lane_cfg_sequencer #(
    .LANES         (LANES),
    .RESET_PATTERN (4'hA),
    .CHECK_WAIT    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .bit_valid_i (bit_valid_i),
    .bit_i       (bit_i),
    .bit_ready_o (bit_ready_o),
    .lane_data_o (lane_data_o),
    .lane_o_i    (lane_o_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a load is "active" from the accepted start
  // until the done cycle; bits are collected into an array; once all lanes
  // are in, m_post counts cycles since the last bit (0 = commit cycle,
  // 1..CW = readback wait, CW+1 = done cycle).
  bit               model_ok = 1'b0;
  bit               m_active;
  int               m_got;
  int               m_post;
  logic [LANES-1:0] m_shadow;
  logic [LANES-1:0] m_data;
  bit               m_err;

  always @(posedge clk) begin
    if (rst) begin
      model_ok = 1'b1;
      m_active = 1'b0;
      m_got    = 0;
      m_post   = 0;
      m_shadow = '0;
      m_data   = 4'hA;
      m_err    = 1'b0;
    end else if (!m_active) begin
      if (start_i) begin
        m_active = 1'b1;
        m_got    = 0;
        m_post   = 0;
        m_shadow = '0;
        m_err    = 1'b0;
      end
    end else if (m_got < LANES) begin
      if (bit_valid_i) begin
        m_shadow[m_got] = bit_i;
        m_got++;
      end
    end else begin
      if (m_post == 0) m_data = m_shadow;
      if (m_post == CW && lane_o_i != m_data) m_err = 1'b1;
      if (m_post == CW + 1) m_active = 1'b0;
      else m_post++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("m_busy",  busy_o,      m_active);
      check("m_ready", bit_ready_o, m_active && (m_got < LANES));
      check("m_done",  done_o,      m_active && (m_got == LANES) && (m_post == CW + 1));
      check("m_data",  lane_data_o, m_data);
      check("m_err",   err_o,       m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full load of pat; optional stall before bit index stall_at; checks that
  // old data holds through COMMIT, new data appears after, and done timing.
  task automatic run_load(input logic [LANES-1:0] pat, input int stall_at, input int stall_len,
                          input int exp_done, input logic exp_err,
                          input logic pulse_in_load, input logic start_in_done);
    int rel;
    logic [LANES-1:0] old;
    old = last_pat;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    rel = 1;
    check("err_clr_on_start", err_o, 1'b0);
    for (int i = 0; i < LANES; i++) begin
      if (i == stall_at) begin
        repeat (stall_len) begin
          bit_valid_i = 1'b0;
          step();
          rel++;
        end
      end
      bit_valid_i = 1'b1;
      bit_i = pat[i];
      start_i = pulse_in_load && (i == 1);
      step();
      rel++;
      start_i = 1'b0;
    end
    bit_valid_i = 1'b0;
    bit_i = 1'b0;
    while (!done_o && rel < 40) begin
      if (rel == exp_done - CW - 1) check("data_held_commit", lane_data_o, old);
      if (rel == exp_done - CW)     check("data_new", lane_data_o, pat);
      step();
      rel++;
    end
    check("done_cycle", rel, exp_done);
    check("err_at_done", err_o, exp_err);
    last_pat = pat;
    start_i = start_in_done;
    step();
    start_i = 1'b0;
    check("idle_after_done", busy_o, 1'b0);
    step();
    check("still_idle", busy_o, 1'b0);
    check("no_done", done_o, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_pat = 4'hA;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    last_pat = 4'hA;
    step();
    step();
    rst = 1'b0;
    check("rst_data",  lane_data_o, 4'hA);
    check("rst_busy",  busy_o, 1'b0);
    check("rst_done",  done_o, 1'b0);
    check("rst_err",   err_o, 1'b0);
    check("rst_ready", bit_ready_o, 1'b0);
    step();

    // bits 1,0,1,0 -> 4'h5, done in cycle 7
    run_load(4'h5, -1, 0, 7, 1'b0, 1'b0, 1'b0);

    // same load from reset with a 3-cycle stall before the third bit
    do_reset();
    run_load(4'h5, 2, 3, 10, 1'b0, 1'b0, 1'b0);

    // readback tied low: mismatch is sticky until the next accepted start
    tie_en = 1'b1;
    tie_val = 4'h0;
    run_load(4'h3, -1, 0, 7, 1'b1, 1'b0, 1'b0);
    step();
    check("err_sticky", err_o, 1'b1);
    tie_en = 1'b0;
    run_load(4'h6, -1, 0, 7, 1'b0, 1'b0, 1'b0);

    // start pulses during LOAD and in DONE are ignored
    run_load(4'h9, -1, 0, 7, 1'b0, 1'b1, 1'b1);

    // abort a load after two bits, then a clean load of 4'hC
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    bit_valid_i = 1'b1;
    bit_i = 1'b1;
    step();
    step();
    bit_valid_i = 1'b0;
    do_reset();
    check("abort_data",  lane_data_o, 4'hA);
    check("abort_busy",  busy_o, 1'b0);
    check("abort_ready", bit_ready_o, 1'b0);
    run_load(4'hC, -1, 0, 7, 1'b0, 1'b0, 1'b0);
    check("final_data", lane_data_o, 4'hC);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
